lbist_controller: RTL and testbench
===================================

Name: lbist_controller

Overview:
- On-chip logic BIST controller inside riscv_wrapper. It responds to the `start`/`go_nogo` handshake driven by the testbench top.
- While `start` is high it takes the core-side cut into test mode and drives pseudo-random patterns from a Galois LFSR. It compacts the cut responses in a MISR and compares the final signature against a golden value.
- It reports pass/fail on `go_nogo_o` and hands the core back to functional mode.

Parameters:
- PAT_WIDTH, 32, LFSR width and pattern bus width.
- RSP_WIDTH, 32, MISR width and response bus width.
- LFSR_POLY, 32'h8020_0003, Galois feedback taps of the LFSR.
- MISR_POLY, 32'h04C1_1DB7, Galois feedback taps of the MISR.
- SEED, 32'hACE1_2468, LFSR seed; must be non-zero (elaboration assertion).
- N_PATTERNS, 1024, number of patterns applied; must be ≥ 1.
- RST_CYCLES, 4, cycles the cut is held in reset before patterns start; must be ≥ 1.
- RESP_LAT, 2, cycles from a pattern being applied to its response being valid; may be 0.
- GOLDEN_SIG, 32'h0, expected final MISR value; set per netlist.

Ports:
- clk_i  in  1  clock.
- rst_ni  in  1  asynchronous active-low reset.
- start_i  in  1  level request; high means run BIST, low means functional mode.
- go_nogo_o  out  1  sticky pass flag.
- done_o  out  1  sticky completion flag.
- test_mode_o  out  1  selects BIST patterns into the cut instead of functional inputs.
- cut_rst_no  out  1  active-low reset to the cut during BIST.
- pattern_o  out  PAT_WIDTH  current LFSR state.
- response_i  in  RSP_WIDTH  cut response.
- signature_o  out  RSP_WIDTH  current MISR value, for debug.

Behaviour:
- Reset values:
  - FSM in IDLE, LFSR = SEED, MISR = 0, counters = 0.
  - go_nogo_o = 0, done_o = 0, test_mode_o = 0, cut_rst_no = 1.
  - Every output is driven from a flop.
- FSM states: IDLE, INIT, CUT_RST, RUN, FLUSH, COMPARE, DONE.
- IDLE:
  - Go to INIT on a clock edge where start_i = 1 and done_o = 0.
  - While done_o = 1, a new run requires start_i low for at least one cycle and then high again (rising-edge rearm).
- INIT (1 cycle):
  - LFSR ← SEED, MISR ← 0, go_nogo_o ← 0, done_o ← 0, test_mode_o ← 1.
- CUT_RST (RST_CYCLES cycles):
  - cut_rst_no = 0; the LFSR is held.
- RUN (N_PATTERNS cycles):
  - cut_rst_no = 1; one pattern per cycle.
  - LFSR_next = {lfsr[W-2:0],1'b0} ^ (lfsr[W-1] ? LFSR_POLY : 0).
  - Pattern counter width is $clog2(N_PATTERNS+1).
- Response capture:
  - A RESP_LAT-deep valid shift register tracks each applied pattern.
  - The MISR updates only when the delayed valid is 1:
    - misr_next = {misr[W-2:0],1'b0} ^ (misr[W-1] ? MISR_POLY : 0) ^ response_i.
  - With RESP_LAT = 0 the response is compacted in the same cycle its pattern is applied.
- FLUSH (RESP_LAT cycles, skipped when 0):
  - The LFSR is held and the remaining responses are compacted.
  - Exactly N_PATTERNS MISR updates occur per run.
- COMPARE (1 cycle):
  - go_nogo_o ← (misr == GOLDEN_SIG); done_o ← 1; test_mode_o ← 0.
- Transition to DONE.
- DONE:
  - go_nogo_o and done_o hold their values; start_i falling does not clear them, so the bench can sample pass/fail after releasing start.
  - Go to IDLE when start_i = 0. In IDLE the flags are still held until the next INIT.
- Latency: done_o rises on the edge 2 + RST_CYCLES + N_PATTERNS + RESP_LAT cycles after the edge that samples start_i = 1 in IDLE.
- Abort:
  - If start_i drops in any state from INIT through FLUSH, return to IDLE on that edge.
  - On abort: test_mode_o = 0, cut_rst_no = 1, go_nogo_o = 0, done_o = 0.
- Reset mid-run: asynchronously return to the reset values; no partial result survives.
- signature_o continuously reflects the MISR register.

Decomposition:
- Package lbist_pkg holds:
  - the state enum typedef;
  - the default LFSR_POLY and MISR_POLY constants;
  - a function galois_step(state, poly), used by both LFSR and MISR.
- One sub-module, lbist_misr, holds the MISR register with enable and synchronous clear.
- The LFSR, counters and FSM stay in lbist_controller.

Test Plan:
- Setup for all scenarios: PAT_WIDTH = RSP_WIDTH = 8, LFSR_POLY = 8'hB8, SEED = 8'h01, N_PATTERNS = 8, RST_CYCLES = 2, RESP_LAT = 1, response_i = pattern_o delayed 1 cycle.
  - GOLDEN_SIG comes from the bench model; start_i rises at cycle 0.
  - Expected: done_o = 1 and go_nogo_o = 1 at cycle 13.
  - Expected: exactly 2 cycles of cut_rst_no = 0, and 8 distinct non-zero patterns.
- Same setup with GOLDEN_SIG mismatched by one bit → done_o = 1, go_nogo_o = 0 at cycle 13; test_mode_o = 0 afterwards.
- Pass run, then start_i dropped at the edge where done_o rises, then checked 2 cycles later → go_nogo_o still 1.
- Pass run, then start_i low for 1 cycle and high again → a new run starts; flags clear in INIT and reassert 13 cycles after the rearm edge with the identical signature.
- start_i dropped in RUN after pattern 3 → next edge: IDLE, test_mode_o = 0, done_o = 0, go_nogo_o = 0.
- rst_ni pulsed low mid-FLUSH → all outputs take their reset values immediately, without waiting for a clock edge; with start_i held high, a fresh run completes 13 cycles after reset release.

Source files
------------

// File: rtl/lbist_pkg.sv
// Shared types and helpers for the logic BIST controller.
// Holds the FSM state encoding, default polynomials and the Galois step.
package lbist_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_INIT,
    S_CUT_RST,
    S_RUN,
    S_FLUSH,
    S_COMPARE,
    S_DONE
  } state_e;

  localparam logic [31:0] DEF_LFSR_POLY = 32'h8020_0003;
  localparam logic [31:0] DEF_MISR_POLY = 32'h04C1_1DB7;

  // One Galois shift of a w-bit register held in the low bits of s.
  function automatic logic [63:0] galois_step(
    input logic [63:0] s,
    input logic [63:0] poly,
    input int          w
  );
    logic [63:0] mask;
    logic [63:0] msb;
    mask = (64'd1 << w) - 64'd1;
    msb  = s & (64'd1 << (w - 1));
    return ((s << 1) ^ ((msb != '0) ? poly : '0)) & mask;
  endfunction

endpackage

// File: rtl/lbist_misr.sv
// Multiple-input signature register compacting cut responses.
// Synchronous clear wins over enable.
module lbist_misr
  import lbist_pkg::*;
#(
  parameter int           W    = 32,
  parameter logic [W-1:0] POLY = W'(DEF_MISR_POLY)
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         en,
  input  logic         clr,
  input  logic [W-1:0] response,
  output logic [W-1:0] sig
);

  logic [W-1:0] nxt;

  assign nxt = W'(galois_step(64'(sig), 64'(POLY), W)) ^ response;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sig <= '0;
    end else if (clr) begin
      sig <= '0;
    end else if (en) begin
      sig <= nxt;
    end
  end

endmodule

// File: rtl/lbist_controller.sv
// Logic BIST controller: LFSR pattern source, cut reset sequencing,
// MISR compaction and golden-signature go/no-go reporting.
module lbist_controller
  import lbist_pkg::*;
#(
  parameter int                   PAT_WIDTH  = 32,
  parameter int                   RSP_WIDTH  = 32,
  parameter logic [PAT_WIDTH-1:0] LFSR_POLY  = PAT_WIDTH'(DEF_LFSR_POLY),
  parameter logic [RSP_WIDTH-1:0] MISR_POLY  = RSP_WIDTH'(DEF_MISR_POLY),
  parameter logic [PAT_WIDTH-1:0] SEED       = PAT_WIDTH'(32'hACE1_2468),
  parameter int                   N_PATTERNS = 1024,
  parameter int                   RST_CYCLES = 4,
  parameter int                   RESP_LAT   = 2,
  parameter logic [RSP_WIDTH-1:0] GOLDEN_SIG = '0
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 start_i,
  output logic                 go_nogo_o,
  output logic                 done_o,
  output logic                 test_mode_o,
  output logic                 cut_rst_no,
  output logic [PAT_WIDTH-1:0] pattern_o,
  input  logic [RSP_WIDTH-1:0] response_i,
  output logic [RSP_WIDTH-1:0] signature_o
);

  localparam int PCW   = $clog2(N_PATTERNS + 1);
  localparam int MAXPH = (RST_CYCLES > RESP_LAT) ? RST_CYCLES : RESP_LAT;
  localparam int HCW   = $clog2(MAXPH + 1);

  if (SEED == '0) begin : g_bad_seed
    $error("lbist_controller: SEED must be non-zero");
  end
  if (N_PATTERNS < 1) begin : g_bad_npat
    $error("lbist_controller: N_PATTERNS must be >= 1");
  end
  if (RST_CYCLES < 1) begin : g_bad_rst
    $error("lbist_controller: RST_CYCLES must be >= 1");
  end

  state_e               state_q, state_d;
  logic [PAT_WIDTH-1:0] lfsr_q, lfsr_d;
  logic [PCW-1:0]       pat_q, pat_d;
  logic [HCW-1:0]       ph_q, ph_d;
  logic                 go_q, go_d;
  logic                 done_q, done_d;
  logic                 tm_q, tm_d;
  logic                 crn_q, crn_d;
  logic                 start_q;
  logic                 run;
  logic                 rsp_vld;
  logic                 misr_en;
  logic                 misr_clr;
  logic [RSP_WIDTH-1:0] sig;

  assign run      = (state_q == S_RUN);
  assign misr_clr = (state_q == S_INIT);
  assign misr_en  = rsp_vld & (run | (state_q == S_FLUSH));

  // Valid pipeline lines each response up with the pattern that caused it.
  if (RESP_LAT > 0) begin : g_pipe
    logic [RESP_LAT-1:0] vld;
    always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
        vld <= '0;
      end else if (misr_clr) begin
        vld <= '0;
      end else begin
        vld[0] <= run;
        for (int i = 1; i < RESP_LAT; i++) begin
          vld[i] <= vld[i-1];
        end
      end
    end
    assign rsp_vld = vld[RESP_LAT-1];
  end else begin : g_nopipe
    assign rsp_vld = run;
  end

  lbist_misr #(
    .W    (RSP_WIDTH),
    .POLY (MISR_POLY)
  ) u_misr (
    .clk      (clk_i),
    .rst_n    (rst_ni),
    .en       (misr_en),
    .clr      (misr_clr),
    .response (response_i),
    .sig      (sig)
  );

  always_comb begin
    state_d = state_q;
    lfsr_d  = lfsr_q;
    pat_d   = pat_q;
    ph_d    = ph_q;
    go_d    = go_q;
    done_d  = done_q;
    tm_d    = tm_q;
    crn_d   = crn_q;
    unique case (state_q)
      S_IDLE: begin
        // After a finished run only a fresh rising start rearms.
        if (start_i && (!done_q || !start_q)) begin
          state_d = S_INIT;
        end
      end
      S_INIT: begin
        lfsr_d  = SEED;
        pat_d   = '0;
        ph_d    = '0;
        go_d    = 1'b0;
        done_d  = 1'b0;
        tm_d    = 1'b1;
        crn_d   = 1'b0;
        state_d = S_CUT_RST;
      end
      S_CUT_RST: begin
        if (ph_q == HCW'(RST_CYCLES - 1)) begin
          ph_d    = '0;
          crn_d   = 1'b1;
          state_d = S_RUN;
        end else begin
          ph_d = ph_q + 1'b1;
        end
      end
      S_RUN: begin
        lfsr_d = PAT_WIDTH'(galois_step(64'(lfsr_q), 64'(LFSR_POLY),
                                        PAT_WIDTH));
        pat_d  = pat_q + 1'b1;
        if (pat_q == PCW'(N_PATTERNS - 1)) begin
          state_d = (RESP_LAT > 0) ? S_FLUSH : S_COMPARE;
        end
      end
      S_FLUSH: begin
        if (ph_q == HCW'(RESP_LAT - 1)) begin
          state_d = S_COMPARE;
        end else begin
          ph_d = ph_q + 1'b1;
        end
      end
      S_COMPARE: begin
        go_d    = (sig == GOLDEN_SIG);
        done_d  = 1'b1;
        tm_d    = 1'b0;
        state_d = S_DONE;
      end
      S_DONE: begin
        if (!start_i) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
    if (!start_i &&
        (state_q inside {S_INIT, S_CUT_RST, S_RUN, S_FLUSH})) begin
      state_d = S_IDLE;
      lfsr_d  = lfsr_q;
      tm_d    = 1'b0;
      crn_d   = 1'b1;
      go_d    = 1'b0;
      done_d  = 1'b0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= S_IDLE;
      lfsr_q  <= SEED;
      pat_q   <= '0;
      ph_q    <= '0;
      go_q    <= 1'b0;
      done_q  <= 1'b0;
      tm_q    <= 1'b0;
      crn_q   <= 1'b1;
      start_q <= 1'b0;
    end else begin
      state_q <= state_d;
      lfsr_q  <= lfsr_d;
      pat_q   <= pat_d;
      ph_q    <= ph_d;
      go_q    <= go_d;
      done_q  <= done_d;
      tm_q    <= tm_d;
      crn_q   <= crn_d;
      start_q <= start_i;
    end
  end

  assign go_nogo_o   = go_q;
  assign done_o      = done_q;
  assign test_mode_o = tm_q;
  assign cut_rst_no  = crn_q;
  assign pattern_o   = lfsr_q;
  assign signature_o = sig;

endmodule

// File: tb/tb_lbist_controller.sv
// Scoreboard bench for lbist_controller on a small 8-bit configuration.
// The cut is modelled as pattern delayed one cycle, XORed with a run key.
module tb_lbist_controller;

  localparam int         W    = 8;
  localparam logic [7:0] LP   = 8'hB8;
  localparam logic [7:0] MP   = 8'hB7;
  localparam logic [7:0] SD   = 8'h01;
  localparam int         NP   = 8;
  localparam int         RC   = 2;
  localparam int         RL   = 1;
  localparam int         LTOT = 2 + RC + NP + RL;

  function automatic logic [7:0] step8(logic [7:0] s, logic [7:0] p);
    return {s[6:0], 1'b0} ^ (s[7] ? p : 8'h00);
  endfunction

  function automatic logic [7:0] run_sig(logic [7:0] k);
    logic [7:0] l;
    logic [7:0] m;
    l = SD;
    m = 8'h00;
    for (int i = 0; i < NP; i++) begin
      m = step8(m, MP) ^ (l ^ k);
      l = step8(l, LP);
    end
    return m;
  endfunction

  localparam logic [7:0] GOLDEN = run_sig(8'h00);

  typedef struct {
    int         due;
    logic       go;
    logic [7:0] sig;
  } exp_t;

  logic       clk;
  logic       rst_n;
  logic       start;
  logic       go_nogo;
  logic       done;
  logic       test_mode;
  logic       cut_rst_n;
  logic [7:0] pattern;
  logic [7:0] response;
  logic [7:0] signature;
  logic [7:0] cut_q;
  logic [7:0] key;

  int   cyc;
  int   tests;
  int   fails;
  logic done_prev;
  exp_t exp_q[$];

  lbist_controller #(
    .PAT_WIDTH  (W),
    .RSP_WIDTH  (W),
    .LFSR_POLY  (LP),
    .MISR_POLY  (MP),
    .SEED       (SD),
    .N_PATTERNS (NP),
    .RST_CYCLES (RC),
    .RESP_LAT   (RL),
    .GOLDEN_SIG (GOLDEN)
  ) dut (
    .clk_i       (clk),
    .rst_ni      (rst_n),
    .start_i     (start),
    .go_nogo_o   (go_nogo),
    .done_o      (done),
    .test_mode_o (test_mode),
    .cut_rst_no  (cut_rst_n),
    .pattern_o   (pattern),
    .response_i  (response),
    .signature_o (signature)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk) cut_q <= pattern;
  assign response = cut_q ^ key;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] want);
    tests++;
    if (act !== want) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)",
               name, act, want, cyc);
    end
  endtask

  task automatic expect_run(input logic [7:0] k);
    exp_t e;
    e.due = cyc + LTOT + 1;
    e.sig = run_sig(k);
    e.go  = (e.sig == GOLDEN);
    exp_q.push_back(e);
  endtask

  task automatic start_run(input logic [7:0] k);
    key   = k;
    start = 1'b1;
    expect_run(k);
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (done && !done_prev) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_done", 32'd1, 32'd0);
      end else begin
        e = exp_q.pop_front();
        chk("done_latency", cyc, e.due);
        chk("go_nogo", {31'd0, go_nogo}, {31'd0, e.go});
        chk("signature", {24'd0, signature}, {24'd0, e.sig});
      end
    end else if (exp_q.size() > 0 && cyc > exp_q[0].due) begin
      e = exp_q.pop_front();
      chk("done_timeout", cyc, e.due);
    end
    done_prev = done;
  end

  initial begin
    logic [7:0] mdl_pat[8];
    logic [7:0] pat_h[16];
    logic       crn_h[16];
    logic [7:0] kbad;
    logic [7:0] l;
    int         lows;
    int         a;
    int         bad;
    int         j;

    tests     = 0;
    fails     = 0;
    done_prev = 1'b0;
    key       = 8'h00;
    start     = 1'b0;
    rst_n     = 1'b0;

    l = SD;
    for (int i = 0; i < NP; i++) begin
      mdl_pat[i] = l;
      l = step8(l, LP);
    end
    kbad = 8'h01;
    for (int k = 255; k >= 1; k--) begin
      if ($countones(run_sig(8'(k)) ^ GOLDEN) == 1) kbad = 8'(k);
    end

    repeat (3) @(negedge clk);
    chk("reset_outputs",
        {16'd0, go_nogo, done, test_mode, cut_rst_n, 4'd0, pattern, signature},
        {16'd0, 1'b0, 1'b0, 1'b0, 1'b1, 4'd0, SD, 8'h00});
    rst_n = 1'b1;
    @(negedge clk);
    chk("idle_after_reset", {29'd0, done, test_mode, cut_rst_n}, 32'd1);

    // Pass run; start released on the edge where done rises.
    start_run(8'h00);
    for (j = 1; j <= 13; j++) begin
      @(negedge clk);
      pat_h[j] = pattern;
      crn_h[j] = cut_rst_n;
      if (j == 13) start = 1'b0;
    end
    lows = 0;
    a    = 0;
    for (int i = 1; i <= 13; i++) begin
      if (!crn_h[i]) lows++;
      if (i > 1 && a == 0 && !crn_h[i-1] && crn_h[i]) a = i;
    end
    chk("cut_rst_low_cycles", lows, 2);
    if (a == 0 || a > 6) a = 1;
    bad = 0;
    for (int i = 0; i < NP; i++) begin
      if (pat_h[a+i] !== mdl_pat[i]) bad++;
    end
    chk("pattern_sequence", bad, 0);
    bad = 0;
    for (int i = 0; i < NP; i++) begin
      if (pat_h[a+i] == 8'h00) bad++;
      for (int m = 0; m < i; m++) begin
        if (pat_h[a+i] == pat_h[a+m]) bad++;
      end
    end
    chk("patterns_distinct_nonzero", bad, 0);
    @(negedge clk);
    repeat (2) @(negedge clk);
    chk("sticky_after_release", {30'd0, go_nogo, done}, 32'd3);

    // Signature one bit off the golden value.
    start_run(kbad);
    repeat (LTOT + 1) @(negedge clk);
    chk("mismatch_flags", {29'd0, done, go_nogo, test_mode}, 32'd4);
    start = 1'b0;
    repeat (2) @(negedge clk);
    chk("mismatch_test_mode_off", {31'd0, test_mode}, 32'd0);

    // Pass run held high, then one-cycle low rearm.
    start_run(8'h00);
    repeat (LTOT + 1) @(negedge clk);
    repeat (3) @(negedge clk);
    chk("no_restart_while_high", {30'd0, done, test_mode}, 32'd2);
    start = 1'b0;
    @(negedge clk);
    start_run(8'h00);
    repeat (3) @(negedge clk);
    chk("flags_clear_on_rearm", {30'd0, done, go_nogo}, 32'd0);
    repeat (LTOT - 2) @(negedge clk);
    start = 1'b0;
    repeat (2) @(negedge clk);

    // Abort in RUN after pattern 3.
    start_run(8'h00);
    repeat (7) @(negedge clk);
    start = 1'b0;
    void'(exp_q.pop_back());
    @(negedge clk);
    chk("abort_outputs", {28'd0, test_mode, done, go_nogo, cut_rst_n}, 32'd1);

    // Asynchronous reset in FLUSH, start held high throughout.
    @(negedge clk);
    start_run(8'($urandom_range(0, 255)));
    repeat (12) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("async_reset_outputs",
        {16'd0, go_nogo, done, test_mode, cut_rst_n, 4'd0, pattern, signature},
        {16'd0, 1'b0, 1'b0, 1'b0, 1'b1, 4'd0, SD, 8'h00});
    void'(exp_q.pop_back());
    @(negedge clk);
    rst_n = 1'b1;
    expect_run(key);
    repeat (LTOT + 1) @(negedge clk);
    start = 1'b0;
    repeat (2) @(negedge clk);

    // Randomized runs with random keys, gaps and aborts.
    for (int r = 0; r < 10; r++) begin
      repeat ($urandom_range(1, 4)) @(negedge clk);
      start_run(($urandom_range(0, 1) == 1) ? 8'h00
                                            : 8'($urandom_range(1, 255)));
      if ($urandom_range(0, 2) == 0) begin
        repeat ($urandom_range(1, 12)) @(negedge clk);
        start = 1'b0;
        void'(exp_q.pop_back());
        @(negedge clk);
        chk("rand_abort", {28'd0, test_mode, done, go_nogo, cut_rst_n},
            32'd1);
      end else begin
        repeat (LTOT + 1) @(negedge clk);
        start = 1'b0;
        @(negedge clk);
      end
    end

    repeat (20) @(negedge clk);
    chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
